// File: rtl/rsa_sched_pkg.sv
// Shared definitions for the RSA job scheduler.
// State encoding and watchdog default live here.
package rsa_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/rsa_rr_arbiter.sv
// Round-robin picker: first request at or after the pointer,
// wrapping, as a one-hot grant plus its index.
module rsa_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rsa_sched.sv
// Round-robin scheduler feeding one modexp engine, one job in flight.
// Optional RSA_SCHED_WATCHDOG_EN adds an engine timeout with abort.
module rsa_sched
  import rsa_sched_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int E_BITS         = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]  req_m,
  input  logic [NUM_REQ*E_BITS-1:0] req_e,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      rsp_err,
  input  logic [WIDTH-1:0]          key_n,
  input  logic [WIDTH-1:0]          key_n_inv,
  input  logic [WIDTH-1:0]          key_r2,
  output logic                      eng_start,
  output logic [WIDTH-1:0]          eng_m,
  output logic [E_BITS-1:0]         eng_e,
  input  logic [WIDTH-1:0]          eng_c,
  input  logic                      eng_done,
  output logic                      eng_abort,
  output logic                      busy
);

  localparam int IW = $clog2(NUM_REQ);

  state_t              r_state;
  state_t              w_next;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_gnt;
  logic [IW-1:0]       w_idx;
  logic [NUM_REQ-1:0]  w_gnt_oh;
  logic                w_any;
  logic                w_accept;
  logic                w_oor;
  logic                w_timeout;
  logic                w_rsp_hs;
  logic [WIDTH-1:0]    w_m_sel;
  logic [E_BITS-1:0]   w_e_sel;
  logic [WIDTH-1:0]    r_eng_m;
  logic [E_BITS-1:0]   r_eng_e;
  logic [WIDTH-1:0]    r_rsp_data;
  logic                r_rsp_err;
  logic                w_unused_key;

  rsa_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt_oh),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_m_sel  = req_m[int'(w_idx)*WIDTH +: WIDTH];
  assign w_e_sel  = req_e[int'(w_idx)*E_BITS +: E_BITS];
  assign w_accept = w_any && |(req_valid & req_ready);
  assign w_oor    = (w_m_sel >= key_n);
  assign w_rsp_hs = (r_state == S_RESP) && rsp_ready[r_gnt];

  // Montgomery constants belong to the engine, not to scheduling.
  assign w_unused_key = ^{key_n_inv, key_r2};

`ifdef RSA_SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] r_wd;

  always_ff @(posedge clk) begin
    if (rst || r_state != S_WAIT) r_wd <= '0;
    else                          r_wd <= r_wd + 1'b1;
  end

  // A done arriving on the timeout cycle still wins.
  assign w_timeout = (r_state == S_WAIT) && !eng_done &&
                     (r_wd == WDW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_timeout    = 1'b0;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = w_oor ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (eng_done || w_timeout) w_next = S_RESP;
      S_RESP:  if (w_rsp_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_gnt      <= '0;
      r_eng_m    <= '0;
      r_eng_e    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gnt   <= w_idx;
        r_eng_m <= w_m_sel;
        r_eng_e <= w_e_sel;
        if (w_oor) begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
        end
      end
      if (r_state == S_WAIT) begin
        if (eng_done) begin
          r_rsp_data <= eng_c;
          r_rsp_err  <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
        end
      end
      if (w_rsp_hs)
        r_rr_ptr <= (r_gnt == IW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (r_state == S_IDLE && !rst) req_ready = w_gnt_oh;
    if (r_state == S_RESP) rsp_valid = NUM_REQ'(1) << r_gnt;
    eng_start = (r_state == S_ISSUE);
    eng_abort = w_timeout;
    busy      = (r_state != S_IDLE);
    eng_m     = r_eng_m;
    eng_e     = r_eng_e;
    rsp_data  = r_rsp_data;
    rsp_err   = r_rsp_err;
  end

endmodule

// File: doc/rsa_sched.md
RSA_SCHED -- requirements
Module: rsa_sched

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, operand/modulus width; E_BITS, 32, exponent width; NUM_REQ, 2, requester count (2..8); TIMEOUT_CYCLES, 4096, engine watchdog limit.
REQ-002 Ports SHALL be: clk  in  1  clock; rst  in  1  reset (synchronous, active-high).
REQ-003 req_valid  in  NUM_REQ  per-requester job valid; req_ready  out  NUM_REQ  per-requester job accept.
REQ-004 req_m  in  NUM_REQ*WIDTH  packed messages; req_e  in  NUM_REQ*E_BITS  packed exponents (slice i belongs to requester i).
REQ-005 rsp_valid  out  NUM_REQ  per-requester result valid; rsp_ready  in  NUM_REQ  per-requester result accept; rsp_data  out  WIDTH  result; rsp_err  out  1  error flag qualifying rsp_data.
REQ-006 key_n, key_n_inv, key_r2  in  WIDTH each  shared key (static while busy); passed straight through to engine.
REQ-007 eng_start  out  1  engine start pulse; eng_m  out  WIDTH; eng_e  out  E_BITS; eng_c  in  WIDTH; eng_done  in  1; eng_abort  out  1  engine reset request; busy  out  1  not IDLE.
Reset behaviour: reset rst, synchronous, active-high; clock clk.

Function
REQ-008 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one job in flight at a time.
REQ-009 IDLE: grant SHALL go to the first requester with req_valid at or after rr_ptr (wrapping mod NUM_REQ); req_ready is asserted combinationally for that index only, and only in IDLE.
REQ-010 On req_valid&req_ready: latch grant index, eng_m, eng_e; if req_m slice >= key_n, go to RESP with rsp_err=1, rsp_data=0 (engine not used); else go to ISSUE.
REQ-011 ISSUE: eng_start SHALL be 1 for exactly one cycle (the cycle after accept), then go to WAIT.
REQ-012 WAIT: on eng_done, capture eng_c into rsp_data with rsp_err=0 and go to RESP; eng_done in any other state SHALL be ignored.
REQ-013 RESP: rsp_valid[g]=1 with data/err stable until rsp_ready[g]; on handshake rr_ptr <= (g+1) mod NUM_REQ, go to IDLE.
REQ-014 Minimum accept-to-next-accept turnaround SHALL be engine latency + 3 cycles when rsp_ready is held high.
REQ-015 eng_m/eng_e SHALL stay constant from accept until return to IDLE.
REQ-016 Requesters not granted SHALL see req_ready=0 and rsp_valid=0; no starvation: a continuously valid requester is served within NUM_REQ jobs.

Reset
REQ-017 On rst: state IDLE, rr_ptr 0, req_ready 0 (combinational, follows IDLE), rsp_valid 0, rsp_data 0, rsp_err 0, eng_start 0, eng_abort 0, busy 0, watchdog 0.
REQ-018 rst mid-job SHALL abandon the job without response; engine shares rst, so no eng_abort is issued.

Configuration
REQ-019 Macro RSA_SCHED_WATCHDOG_EN: when defined, WAIT counts cycles; on reaching TIMEOUT_CYCLES without eng_done, eng_abort pulses one cycle and state goes to RESP with rsp_err=1, rsp_data=0; eng_done in the same cycle as timeout SHALL win (normal result).
REQ-020 Without RSA_SCHED_WATCHDOG_EN: no counter, eng_abort tied 0, WAIT waits indefinitely.

Structure
REQ-021 Shared package SHALL hold the state encoding constants and the default TIMEOUT_CYCLES value.
REQ-022 One sub-module rsa_rr_arbiter (request vector + pointer -> one-hot grant + index) SHALL be instantiated; rest is flat.

Verification
REQ-023 Single job: WIDTH=32, key_n=3233, req0 M=65 E=17 -> eng_start one cycle after accept; rsp_valid[0], rsp_data=2790, rsp_err=0.
REQ-024 Contention: req0 and req1 valid together from reset -> req0 served first, then req1; repeat with both held -> strict alternation 0,1,0,1.
REQ-025 Range check: req1 M=3233 (=key_n) -> no eng_start, rsp_err=1, rsp_data=0 within 2 cycles of accept.
REQ-026 Backpressure: rsp_ready low 10 cycles -> rsp_valid/rsp_data held; no new req_ready during that time.
REQ-027 Watchdog (macro defined, TIMEOUT_CYCLES=16, stub engine never done) -> eng_abort pulse at cycle 16 of WAIT, rsp_err=1; stub done on cycle 16 -> normal result.
REQ-028 rst asserted in WAIT -> next cycle all outputs at reset values, rr_ptr 0, late eng_done ignored.
